// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage and IF/ID pipeline register. Owns the PC, reads
// 16-bit words from a combinational instruction memory, joins two-word
// instructions (opcode word + immediate word) and presents one complete
// instruction per valid cycle to the decode/control stage.
//
// Ports:
//   clk          system clock, all state updates on rising edge
//   reset        synchronous active-low reset
//   stall        hold all state (hazard logic)
//   redirect_en  flush IF/ID and load redirect_pc
//   redirect_pc  redirect target
//   imem_addr    instruction-memory address (= pc)
//   imem_data    instruction word at imem_addr (same-cycle read)
//   if_valid     IF/ID holds a real instruction
//   if_opcode    word[15:9], NOP_OP on bubbles
//   if_rdst      word[8:6]
//   if_rsrc      word[5:3]
//   if_imm       second word of two-word instructions, else 0
//   if_pc        address of the instruction's first word
//   halted       fetch is stopped after HLT
//
// State table:
//   state     | meaning
//   ----------+---------------------------------------------------------
//   FETCH     | pc points at the first word of the next instruction
//   FETCH_IMM | first word latched in pending regs, pc points at its imm
//   HALTED    | HLT issued, pc frozen, IF/ID held as bubble
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int          ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [6:0]  NOP_OP   = 7'b1101000,
    parameter logic [6:0]  HLT_OP   = 7'b1100001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic              if_valid,
    output logic [6:0]        if_opcode,
    output logic [2:0]        if_rdst,
    output logic [2:0]        if_rsrc,
    output logic [15:0]       if_imm,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);

    localparam logic [6:0] IADD_OP = 7'b0100000;
    localparam logic [6:0] LDM_OP  = 7'b0110101;
    localparam logic [6:0] LDD_OP  = 7'b0100010;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        FETCH_IMM = 2'd1,
        HALTED    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // first word of a two-word instruction, waiting for its immediate
    logic [6:0]        pend_op_q, pend_op_d;
    logic [2:0]        pend_rdst_q, pend_rdst_d;
    logic [2:0]        pend_rsrc_q, pend_rsrc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    // IF/ID register
    logic              valid_q, valid_d;
    logic [6:0]        op_q, op_d;
    logic [2:0]        rdst_q, rdst_d;
    logic [2:0]        rsrc_q, rsrc_d;
    logic [15:0]       imm_q, imm_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;

    logic [6:0]        word_op;
    logic [2:0]        word_rdst;
    logic [2:0]        word_rsrc;
    logic              word_two;
    logic [ADDR_W-1:0] pc_inc;
    logic              unused_word_bits;

    assign word_op   = imem_data[15:9];
    assign word_rdst = imem_data[8:6];
    assign word_rsrc = imem_data[5:3];
    assign word_two  = (word_op == IADD_OP) || (word_op == LDM_OP) ||
                       (word_op == LDD_OP);
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign unused_word_bits = ^imem_data[2:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            pend_op_q   <= '0;
            pend_rdst_q <= '0;
            pend_rsrc_q <= '0;
            pend_pc_q   <= '0;
            valid_q     <= 1'b0;
            op_q        <= NOP_OP;
            rdst_q      <= '0;
            rsrc_q      <= '0;
            imm_q       <= '0;
            ipc_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_op_q   <= pend_op_d;
            pend_rdst_q <= pend_rdst_d;
            pend_rsrc_q <= pend_rsrc_d;
            pend_pc_q   <= pend_pc_d;
            valid_q     <= valid_d;
            op_q        <= op_d;
            rdst_q      <= rdst_d;
            rsrc_q      <= rsrc_d;
            imm_q       <= imm_d;
            ipc_q       <= ipc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_op_d   = pend_op_q;
        pend_rdst_d = pend_rdst_q;
        pend_rsrc_d = pend_rsrc_q;
        pend_pc_d   = pend_pc_q;
        valid_d     = valid_q;
        op_d        = op_q;
        rdst_d      = rdst_q;
        rsrc_d      = rsrc_q;
        imm_d       = imm_q;
        ipc_d       = ipc_q;

        // redirect beats stall; it has no effect once halted
        if (redirect_en && (state_q != HALTED)) begin
            state_d = FETCH;
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            op_d    = NOP_OP;
            rdst_d  = '0;
            rsrc_d  = '0;
            imm_d   = '0;
            ipc_d   = '0;
        end else if (!stall) begin
            case (state_q)
                FETCH: begin
                    pc_d = pc_inc;
                    if (word_two) begin
                        pend_op_d   = word_op;
                        pend_rdst_d = word_rdst;
                        pend_rsrc_d = word_rsrc;
                        pend_pc_d   = pc_q;
                        state_d     = FETCH_IMM;
                        valid_d     = 1'b0;
                        op_d        = NOP_OP;
                        rdst_d      = '0;
                        rsrc_d      = '0;
                        imm_d       = '0;
                        ipc_d       = '0;
                    end else begin
                        valid_d = 1'b1;
                        op_d    = word_op;
                        rdst_d  = word_rdst;
                        rsrc_d  = word_rsrc;
                        imm_d   = '0;
                        ipc_d   = pc_q;
                        if (word_op == HLT_OP) begin
                            state_d = HALTED;
                        end
                    end
                end
                FETCH_IMM: begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                    valid_d = 1'b1;
                    op_d    = pend_op_q;
                    rdst_d  = pend_rdst_q;
                    rsrc_d  = pend_rsrc_q;
                    imm_d   = imem_data;
                    ipc_d   = pend_pc_q;
                end
                HALTED: begin
                    valid_d = 1'b0;
                    op_d    = NOP_OP;
                    rdst_d  = '0;
                    rsrc_d  = '0;
                    imm_d   = '0;
                    ipc_d   = '0;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_opcode = op_q;
    assign if_rdst   = rdst_q;
    assign if_rsrc   = rsrc_q;
    assign if_imm    = imm_q;
    assign if_pc     = ipc_q;
    assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit from a behavioural instruction memory, runs the directed
// scenarios followed by a randomized phase, and compares every output after
// every edge against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int         AW      = 12;
    localparam logic [6:0] NOP     = 7'b1101000;
    localparam logic [6:0] HLT     = 7'b1100001;
    localparam logic [6:0] IADD    = 7'b0100000;
    localparam logic [6:0] LDM     = 7'b0110101;
    localparam logic [6:0] LDD     = 7'b0100010;
    localparam logic [6:0] ADD     = 7'b0000001;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          redirect_en;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_data;
    logic          if_valid;
    logic [6:0]    if_opcode;
    logic [2:0]    if_rdst;
    logic [2:0]    if_rsrc;
    logic [15:0]   if_imm;
    logic [AW-1:0] if_pc;
    logic          halted;

    logic [15:0]   mem [0:(1<<AW)-1];

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: architectural view of the fetch stage
    logic [AW-1:0] m_pc;
    bit            m_have_first;   // first word of a two-word instr captured
    bit            m_halt;
    logic [15:0]   m_first;
    logic [AW-1:0] m_first_pc;
    bit            e_valid;
    logic [6:0]    e_op;
    logic [2:0]    e_rdst, e_rsrc;
    logic [15:0]   e_imm;
    logic [AW-1:0] e_pc;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_unit #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_valid    (if_valid),
        .if_opcode   (if_opcode),
        .if_rdst     (if_rdst),
        .if_rsrc     (if_rsrc),
        .if_imm      (if_imm),
        .if_pc       (if_pc),
        .halted      (halted)
    );

    function automatic bit is_two_word(input logic [6:0] op);
        return (op == IADD) || (op == LDM) || (op == LDD);
    endfunction

    function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs);
        return {op, rd, rs, 3'b000};
    endfunction

    task automatic bubble();
        e_valid = 0; e_op = NOP; e_rdst = 0; e_rsrc = 0; e_imm = 0; e_pc = 0;
    endtask

    task automatic emit(input logic [15:0] w, input logic [15:0] imm,
                        input logic [AW-1:0] at);
        e_valid = 1; e_op = w[15:9]; e_rdst = w[8:6]; e_rsrc = w[5:3];
        e_imm = imm; e_pc = at;
    endtask

    task automatic model_edge(input bit rst_n, input bit stl, input bit red,
                              input logic [AW-1:0] rpc);
        logic [15:0] w;
        w = mem[m_pc];
        if (!rst_n) begin
            m_pc = '0; m_have_first = 0; m_halt = 0; bubble();
        end else if (red && !m_halt) begin
            m_pc = rpc; m_have_first = 0; bubble();
        end else if (stl) begin
            // nothing changes
        end else if (m_halt) begin
            bubble();
        end else if (m_have_first) begin
            emit(m_first, w, m_first_pc);
            m_have_first = 0;
            m_pc = m_pc + 1'b1;
        end else if (is_two_word(w[15:9])) begin
            m_first = w; m_first_pc = m_pc; m_have_first = 1;
            m_pc = m_pc + 1'b1;
            bubble();
        end else begin
            emit(w, 16'h0, m_pc);
            if (w[15:9] == HLT) m_halt = 1;
            m_pc = m_pc + 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("if_valid",  32'(if_valid),  32'(e_valid));
        chk("if_opcode", 32'(if_opcode), 32'(e_op));
        chk("if_rdst",   32'(if_rdst),   32'(e_rdst));
        chk("if_rsrc",   32'(if_rsrc),   32'(e_rsrc));
        chk("if_imm",    32'(if_imm),    32'(e_imm));
        chk("if_pc",     32'(if_pc),     32'(e_pc));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("halted",    32'(halted),    32'(m_halt));
    endtask

    // one clock: drive inputs, advance model, sample #1 after the edge
    task automatic step(input bit rst_n, input bit stl, input bit red,
                        input logic [AW-1:0] rpc);
        reset = rst_n; stall = stl; redirect_en = red; redirect_pc = rpc;
        model_edge(rst_n, stl, red, rpc);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = mk(NOP, 3'd0, 3'd0);
        mem[0] = mk(ADD, 3'd2, 3'd3);
        mem[1] = mk(IADD, 3'd1, 3'd0);
        mem[2] = 16'hBEEF;
        mem[3] = mk(LDM, 3'd4, 3'd5);
        mem[4] = 16'h1234;
        mem[5] = mk(HLT, 3'd0, 3'd0);
        mem[12'h040] = mk(ADD, 3'd6, 3'd7);
        mem[12'hFFF] = mk(LDM, 3'd3, 3'd1);

        reset = 0; stall = 0; redirect_en = 0; redirect_pc = '0;
        m_pc = '0; m_have_first = 0; m_halt = 0; m_first = '0; m_first_pc = '0;
        bubble();

        // reset state
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("rst_opcode", 32'(if_opcode), 32'(NOP));
        chk("rst_pc", 32'(imem_addr), 32'h0);

        // one-word ADD at 0
        step(1, 0, 0, '0);
        chk("add_op", 32'(if_opcode), 32'(ADD));
        chk("add_rd", 32'(if_rdst), 32'd2);
        chk("add_rs", 32'(if_rsrc), 32'd3);
        chk("add_npc", 32'(imem_addr), 32'd1);

        // two-word IADD at 1
        step(1, 0, 0, '0);
        chk("iadd_bubble", 32'(if_valid), 32'd0);
        step(1, 0, 0, '0);
        chk("iadd_imm", 32'(if_imm), 32'hBEEF);
        chk("iadd_pc", 32'(if_pc), 32'd1);
        chk("iadd_npc", 32'(imem_addr), 32'd3);

        // LDM at 3, stalled for 3 cycles in FETCH_IMM
        step(1, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
        chk("stall_pc", 32'(imem_addr), 32'd4);
        step(1, 0, 0, '0);
        chk("ldm_imm", 32'(if_imm), 32'h1234);
        chk("ldm_pc", 32'(if_pc), 32'd3);

        // HLT at 5
        step(1, 0, 0, '0);
        chk("hlt_valid", 32'(if_valid), 32'd1);
        chk("hlt_op", 32'(if_opcode), 32'(HLT));
        step(1, 0, 0, '0);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(imem_addr), 32'd6);
        step(1, 0, 1, 12'h040);
        step(1, 0, 0, '0);
        chk("halt_hold_pc", 32'(imem_addr), 32'd6);
        step(0, 0, 0, '0);
        chk("unhalt", 32'(halted), 32'd0);

        // redirect with stall while in FETCH_IMM: pending IADD dropped
        step(1, 0, 0, '0);     // ADD @0
        step(1, 0, 0, '0);     // IADD first word @1
        step(1, 1, 1, 12'h040);
        chk("redir_pc", 32'(imem_addr), 32'h040);
        chk("redir_bubble", 32'(if_valid), 32'd0);
        step(1, 0, 0, '0);
        chk("redir_ipc", 32'(if_pc), 32'h040);
        chk("redir_op", 32'(if_opcode), 32'(ADD));

        // wrap between the two words of LDM at FFF
        mem[0] = 16'h0007;
        step(1, 0, 1, 12'hFFF);
        step(1, 0, 0, '0);
        chk("wrap_mid_pc", 32'(imem_addr), 32'h000);
        step(1, 0, 0, '0);
        chk("wrap_op", 32'(if_opcode), 32'(LDM));
        chk("wrap_imm", 32'(if_imm), 32'h7);
        chk("wrap_ipc", 32'(if_pc), 32'hFFF);
        chk("wrap_npc", 32'(imem_addr), 32'h001);

        // randomized phase
        for (int i = 0; i < (1 << AW); i++) begin
            int r;
            r = $urandom_range(0, 19);
            case (r)
                0:       mem[i] = {IADD, 9'($urandom)};
                1:       mem[i] = {LDM,  9'($urandom)};
                2:       mem[i] = {LDD,  9'($urandom)};
                3:       mem[i] = {HLT,  9'($urandom)};
                default: mem[i] = 16'($urandom);
            endcase
        end
        for (int i = 0; i < 3000; i++) begin
            bit rn, st, rd;
            rn = ($urandom_range(0, 49) != 0);
            st = ($urandom_range(0, 4) == 0);
            rd = ($urandom_range(0, 14) == 0);
            step(rn, st, rd, AW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
